// File: rtl/mips_md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_md_pkg
// Description : Shared definitions for the EXE-stage multiply/divide unit:
//               op-code encodings, FSM state type and end-to-end latency.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_md_pkg;

    // Mul/div op codes as delivered by the ID/EXE pipeline register
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Cycles from the start edge to the done cycle (32 CALC + FIX + DONE)
    localparam int MD_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage : mips_md_pkg
`default_nettype wire

// File: rtl/md_step_core.sv
`default_nettype none
// ============================================================================
// Module      : md_step_core
// Description : Combinational single radix-2 step shared by multiply and
//               divide.
//               Multiply : shift-add, {acc,q} shifts right, the multiplier
//                          LSB selects whether b is added.
//               Divide   : restoring shift-subtract, {acc,q} shifts left and
//                          the new quotient bit enters at q[0].
// Ports       : acc     - partial product high half / partial remainder
//               q       - multiplier remainder / dividend-then-quotient
//               b       - operand magnitude (multiplicand or divisor)
//               is_div  - 1 selects the divide step
//               acc_nxt - updated accumulator
//               q_nxt   - updated q register
// Revision    : 1.0 - initial release
// ============================================================================
module md_step_core #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   acc,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] b,
    input  logic              is_div,
    output logic [DATA_W:0]   acc_nxt,
    output logic [DATA_W-1:0] q_nxt
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_shl;
    logic [DATA_W:0] w_diff;
    logic            w_ge;

    always_comb begin
        // During a multiply acc stays below 2^DATA_W, so the sum cannot
        // carry out of DATA_W+1 bits.
        w_sum  = acc + (q[0] ? {1'b0, b} : '0);
        // Partial remainder is always < b, so its top bit is zero and the
        // left shift fits in DATA_W+1 bits.
        w_shl  = {acc[DATA_W-1:0], q[DATA_W-1]};
        w_ge   = (w_shl >= {1'b0, b});
        w_diff = w_shl - {1'b0, b};

        if (is_div) begin
            acc_nxt = w_ge ? w_diff : w_shl;
            q_nxt   = {q[DATA_W-2:0], w_ge};
        end else begin
            acc_nxt = {1'b0, w_sum[DATA_W:1]};
            q_nxt   = {w_sum[0], q[DATA_W-1:1]};
        end
    end

endmodule : md_step_core
`default_nettype wire

// File: rtl/pipe_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exe_muldiv
// Description : Iterative EXE-stage multiply/divide unit (MULT, MULTU, DIV,
//               DIVU). Signed operands are converted to magnitudes, one
//               radix-2 step runs per cycle, then signs are restored and the
//               HI/LO result registers are written.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset
//               start - one-cycle request, op/a/b valid with it
//               flush - cancel the in-flight operation
//               op    - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               a, b  - rs / rt operands
//               busy  - stall request while computing (CALC/FIX)
//               done  - one-cycle pulse, hi/lo valid
//               hi    - product high half or remainder
//               lo    - product low half or quotient
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_exe_muldiv
    import mips_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         r_state;
    md_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        r_op;
    logic [DATA_W:0]   r_acc;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_b;
    logic              r_res_neg;
    logic              r_rem_neg;
    logic              r_div0;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_launch;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_acc_nxt;
    logic [DATA_W-1:0] w_q_nxt;
    logic              w_is_div;

    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_rem_mag;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_hi_fix;
    logic [DATA_W-1:0]   w_lo_fix;

    // ------------------------------------------------------------------
    // Operand conditioning at launch
    // ------------------------------------------------------------------
    assign w_launch = (r_state == ST_IDLE) && start && !flush;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[DATA_W-1];
    assign w_b_neg  = w_signed & b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    assign w_is_div = r_op[1];

    md_step_core #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc     (r_acc),
        .q       (r_q),
        .b       (r_b),
        .is_div  (w_is_div),
        .acc_nxt (w_acc_nxt),
        .q_nxt   (w_q_nxt)
    );

    // ------------------------------------------------------------------
    // Sign fixup and result selection
    // ------------------------------------------------------------------
    assign w_prod     = {r_acc[DATA_W-1:0], r_q};
    assign w_prod_fix = r_res_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_rem_mag  = r_acc[DATA_W-1:0];
    assign w_rem_fix  = r_rem_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
    assign w_quo_fix  = r_res_neg ? (~r_q + 1'b1) : r_q;

    // With b==0 every restoring step succeeds, so the remainder ends up as
    // |a|; restoring the dividend sign yields the original a for hi. Only
    // the quotient has to be forced.
    assign w_hi_fix = w_is_div ? w_rem_fix : w_prod_fix[2*DATA_W-1:DATA_W];
    assign w_lo_fix = w_is_div ? (r_div0 ? '1 : w_quo_fix)
                               : w_prod_fix[DATA_W-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_cnt <= CNT_W'(DATA_W - 1);
            end else if ((r_state == ST_CALC) && !flush && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && !flush) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (flush)              w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)   w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_op      <= op;
                        r_acc     <= '0;
                        r_q       <= w_a_mag;
                        r_b       <= w_b_mag;
                        r_res_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_div0    <= (b == '0);
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                end
                ST_FIX: begin
                    if (!flush) begin
                        r_hi <= w_hi_fix;
                        r_lo <= w_lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done = (r_state == ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : pipe_exe_muldiv
`default_nettype wire

// File: tb/tb_pipe_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_exe_muldiv
// Description : Self-checking bench for pipe_exe_muldiv: directed arithmetic
//               and boundary cases, flush/reset/ignored-start scenarios and
//               randomized operations against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_exe_muldiv;
    import mips_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    always #5 clk = ~clk;

    pipe_exe_muldiv #(
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] res;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        res = '0;
        case (o)
            MD_MULT:  res = sx * sy;
            MD_MULTU: res = ux * uy;
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else if (o == MD_DIV) begin
                    sq  = sx / sy;
                    sr  = sx % sy;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    res = {(ux % uy) , 32'b0} | (ux / uy);
                    res = {res[63:32], res[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Launch one operation and follow it for MD_LATENCY+1 cycles.
    // poke_at / flush_at / rst_at: cycle index after the start edge at
    // which start / flush / rst is pulsed for one cycle (0 = never).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke_at, input int flush_at,
                          input int rst_at);
        int          busy_bad;
        int          done_bad;
        int          stop;
        logic        exp_busy;
        logic        exp_done;
        logic [63:0] m;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;
        busy_bad = 0;
        done_bad = 0;
        cap_hi   = '0;
        cap_lo   = '0;
        stop     = (flush_at > 0) ? flush_at : rst_at;
        m        = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        for (int j = 1; j <= MD_LATENCY + 1; j++) begin
            exp_busy = (stop > 0) ? (j <= stop) : (j <= MD_LATENCY - 1);
            exp_done = (stop == 0) && (j == MD_LATENCY);
            if (busy !== exp_busy) busy_bad++;
            if (done !== exp_done) done_bad++;
            if (j == MD_LATENCY) begin
                cap_hi = hi;
                cap_lo = lo;
            end
            start = (j == poke_at);
            flush = (j == flush_at);
            rst   = (j == rst_at);
            if (j <= MD_LATENCY) begin
                @(posedge clk); #1;
                start = 1'b0; flush = 1'b0; rst = 1'b0;
            end
        end
        if (rst_at > 0) begin
            exp_hi = '0;
            exp_lo = '0;
        end else if (flush_at == 0) begin
            exp_hi = m[63:32];
            exp_lo = m[31:0];
            check({tag, "_hi"}, {32'b0, cap_hi}, {32'b0, exp_hi});
            check({tag, "_lo"}, {32'b0, cap_lo}, {32'b0, exp_lo});
        end
        check({tag, "_busy_timing"}, 64'(busy_bad), 64'd0);
        check({tag, "_done_timing"}, 64'(done_bad), 64'd0);
        check({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 7))
            0:       return allow_zero ? 32'd0 : 32'd1;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        // Directed arithmetic
        run_op("mult_neg3x7",  MD_MULT,  32'hFFFF_FFFD, 32'd7,        0, 0, 0);
        run_op("multu_max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("div_neg7_2",   MD_DIV,   32'hFFFF_FFF9, 32'd2,        0, 0, 0);
        run_op("divu_7_2",     MD_DIVU,  32'd7,         32'd2,        0, 0, 0);
        run_op("div_ovf",      MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("divu_by0",     MD_DIVU,  32'h0000_1234, 32'd0,        0, 0, 0);
        run_op("div_by0_neg",  MD_DIV,   32'hFFFF_FF00, 32'd0,        0, 0, 0);

        // Cancel / ignored starts / back-to-back
        run_op("flush_n10",    MD_MULTU, 32'd12345,     32'd678,      0, 10, 0);
        run_op("poke_busy",    MD_DIVU,  32'd1000,      32'd7,        5, 0, 0);
        run_op("poke_done",    MD_MULT,  32'd9,         32'hFFFF_FFFE, MD_LATENCY, 0, 0);
        run_op("after_done",   MD_MULTU, 32'd11,        32'd13,       0, 0, 0);

        // start and flush together in IDLE: nothing launches
        start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        check("idle_flush_done", {63'b0, done}, 64'd0);
        check("idle_flush_hilo", {hi, lo}, {exp_hi, exp_lo});

        // Reset in the middle of a divide, then a fresh multiply
        run_op("rst_mid_div",  MD_DIV,   32'hFFFF_FFF9, 32'd2,        0, 0, 20);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        run_op("multu_3x5",    MD_MULTU, 32'd3,         32'd5,        0, 0, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom), pick(1'b0), pick(1'b1), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_exe_muldiv
`default_nettype wire

// File: doc/pipe_exe_muldiv.md
Name: pipe_exe_muldiv

Overview:
- Iterative multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes the latched rs/rt operands plus a mul/div op code and produces 64-bit HI/LO results for the HI/LO write path.
- Holds a stall request while computing, so the hazard unit freezes IF/ID and ID/EXE.
- One radix-2 step per cycle; covers MULT, MULTU, DIV, DIVU.

Parameters:
- DATA_W, 32: operand width; HI and LO are each DATA_W bits. Only 32 is verified.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; op/a/b valid in the same cycle
- flush  in  1  cancel the in-flight operation (exception/branch squash)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  DATA_W  rs operand (multiplicand / dividend)
- b  in  DATA_W  rt operand (multiplier / divisor)
- busy  out  1  stall request to the hazard unit
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  DATA_W  product[63:32] or remainder
- lo  out  DATA_W  product[31:0] or quotient

Behaviour:
- Synchronous active-high reset. All state updates on the rising edge of clk; rst is sampled only there.
- Reset state: FSM=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- rst overrides everything. Asserting it mid-operation gives reset values after that edge, with no done pulse.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch op.
  - Signed ops: latch |a| and |b|, and record the result sign and the remainder sign.
  - Load counter=DATA_W-1 and go to CALC.
- CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
  - At counter==0, go to FIX; otherwise decrement.
- FIX: apply 2's-complement negation where required, write hi/lo, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.

Timing and handshake:
- start sampled at edge N: busy=1 in cycles N+1..N+33 (32 CALC + 1 FIX).
- done=1 and new hi/lo visible in cycle N+34; busy=0 in DONE.
- hi/lo hold their value until the next FIX. They are never cleared by start or flush.
- start during CALC/FIX is ignored.
- start in DONE is ignored; the next op is accepted only from IDLE.

flush:
- In CALC or FIX: go to IDLE at the next edge. busy=0 and done=0 from then on; hi/lo keep their old values.
- In IDLE: start+flush in the same cycle means flush wins and nothing is launched.
- In DONE: the done pulse and result still complete.

Arithmetic rules:
- Multiply: 64-bit product. Signed ops negate the 64-bit magnitude when a[31]^b[31].
- Division: quotient sign = a[31]^b[31] (signed only). Remainder sign follows the dividend.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero (b==0), both DIV and DIVU: full latency, hi=a (original value), lo=0xFFFFFFFF.
- No internal overflow beyond the 64-bit product; the accumulator is DATA_W+1 bits wide for the subtract.

Decomposition:
- Shared package mips_md_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - FSM state enum
  - MD_LATENCY=34
- One sub-module, md_step_core: the combinational single radix-2 step, taking {acc, q, b, is_div} and returning the next {acc, q}.
- The FSM, counter, sign fixup and output registers live in pipe_exe_muldiv.

Test Plan:
- MULT a=0xFFFFFFFD(-3) b=7, start at N: busy N+1..N+33; done at N+34 only; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=2: lo=3, hi=1.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU 0x1234 / 0: hi=0x1234, lo=0xFFFFFFFF, done still at N+34.
- Cancel and back-to-back:
  - flush at N+10: busy=0 from N+11, no done pulse, hi/lo unchanged.
  - start pulsed at N+5 while busy: ignored.
  - start again at N+34 (DONE): ignored; a start in the following IDLE cycle is accepted.
- rst at N+20 mid-DIV: at the next edge busy=done=hi=lo=0, FSM in IDLE, and a following MULTU 3*5 gives lo=15, hi=0.
